// File: rtl/reg8_rr_arbiter.sv
// Round-robin write arbiter for one shared register: picks one requester,
// issues a single-cycle write with ack, then optionally holds off before re-arbitrating.
module reg8_rr_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic                  reg_ena_o,
    output logic [WIDTH-1:0]      reg_data_o,
    output logic [OW-1:0]         owner_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              ena_q, ena_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_rot;
    logic              win_valid;
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     win_next;
    logic [OW:0]       sum;
    logic [NREQ-1:0]   win_oh;
    logic [WIDTH-1:0]  win_data;

    // ptr_q is the index with highest priority; scanning a rotated copy of req
    // gives the first set bit at or after ptr_q with wrap.
    always_comb begin
        req_dbl   = {req_i, req_i};
        req_rot   = req_dbl >> ptr_q;
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_valid && req_rot[k]) begin
                win_valid = 1'b1;
                sum       = {1'b0, ptr_q} + (OW+1)'(k);
                if (sum >= (OW+1)'(NREQ)) begin
                    sum = sum - (OW+1)'(NREQ);
                end
                win_idx = sum[OW-1:0];
            end
        end
        win_next = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        win_oh   = NREQ'(1) << win_idx;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_oh[k]) begin
                win_data = wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ena_d   = 1'b0;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = GRANT;
                    gnt_d   = win_oh;
                    ena_d   = 1'b1;
                    data_d  = win_data;
                    owner_d = win_idx;
                    ptr_d   = win_next;
                end
            end
            GRANT: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ena_q   <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ena_q   <= ena_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign ack_o      = gnt_q;
    assign reg_ena_o  = ena_q;
    assign reg_data_o = data_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_reg8_rr_arbiter.sv
// Directed bench for reg8_rr_arbiter: one instance with HOLD_CYCLES=2 and one
// with HOLD_CYCLES=0, checked against hand-computed grant sequences.
module tb_reg8_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic        reg_ena;
    logic [7:0]  reg_data;
    logic [1:0]  owner;
    logic        busy;

    logic [3:0]  req0;
    logic [31:0] wdata0;
    logic [3:0]  gnt0, ack0;
    logic        reg_ena0;
    logic [7:0]  reg_data0;
    logic [1:0]  owner0;
    logic        busy0;

    int checks = 0;
    int errors = 0;

    reg8_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .wdata_i(wdata),
        .gnt_o(gnt), .ack_o(ack), .reg_ena_o(reg_ena), .reg_data_o(reg_data),
        .owner_o(owner), .busy_o(busy)
    );

    reg8_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .wdata_i(wdata0),
        .gnt_o(gnt0), .ack_o(ack0), .reg_ena_o(reg_ena0), .reg_data_o(reg_data0),
        .owner_o(owner0), .busy_o(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        wdata = 32'hA3A2A1A0;
        req0  = 4'b0000;
        wdata0 = 32'h0;
        repeat (3) tick();
        checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || reg_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl gnt=%b ack=%b ena=%b required 0000 0000 0", gnt, ack, reg_ena);
        end
        checks++;
        if (reg_data !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_data data=%h busy=%b owner=%0d required 00 0 0", reg_data, busy, owner);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || reg_data !== 8'hA0) begin
            errors++;
            $display("FAIL first_grant gnt=%b data=%h required 0001 a0", gnt, reg_data);
        end
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_single();
        req   = 4'b0100;
        wdata = 32'h001E0000;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0100 || ack !== 4'b0100 || reg_ena !== 1'b1) begin
            errors++;
            $display("FAIL single_grant gnt=%b ack=%b ena=%b required 0100 0100 1", gnt, ack, reg_ena);
        end
        checks++;
        if (reg_data !== 8'h1E || owner !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_data data=%h owner=%0d busy=%b required 1e 2 1", reg_data, owner, busy);
        end
        tick();
        checks++;
        if (reg_ena !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold1 ena=%b gnt=%b busy=%b required 0 0000 1", reg_ena, gnt, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold2 busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || reg_data !== 8'h1E || owner !== 2'd2) begin
            errors++;
            $display("FAIL single_idle busy=%b data=%h owner=%0d required 0 1e 2", busy, reg_data, owner);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wdata = 32'hA3A2A1A0;
        req   = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            tick();
            exp = (c % 4 == 1) ? (4'b0001 << order[(c-1)/4]) : 4'b0000;
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL rr_gnt cycle %0d gnt=%b required %b", c, gnt, exp);
            end
            if (c % 4 == 1) begin
                checks++;
                if (reg_data !== 8'(8'hA0 + order[(c-1)/4])) begin
                    errors++;
                    $display("FAIL rr_data cycle %0d data=%h required %h", c, reg_data,
                             8'(8'hA0 + order[(c-1)/4]));
                end
            end
        end
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_wrap_priority();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL prio_setup gnt=%b owner=%0d required 0010 1", gnt, owner);
        end
        wait_idle();
        req = 4'b1001;
        tick();
        req = 4'b0001;
        checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL prio_first gnt=%b owner=%0d required 1000 3", gnt, owner);
        end
        repeat (4) tick();
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL prio_wrap gnt=%b owner=%0d required 0001 0", gnt, owner);
        end
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_reset_mid_hold();
        wdata = 32'h001E0000;
        req   = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (busy !== 1'b1 || reg_data !== 8'h1E) begin
            errors++;
            $display("FAIL mid_hold_pre busy=%b data=%h required 1 1e", busy, reg_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || reg_ena !== 1'b0 ||
            reg_data !== 8'h00 || owner !== 2'd0) begin
            errors++;
            $display("FAIL mid_hold_rst busy=%b gnt=%b ena=%b data=%h owner=%0d required all zero",
                     busy, gnt, reg_ena, reg_data, owner);
        end
        rst_n = 1'b1;
        wdata = 32'hA3A2A1A0;
        req   = 4'b0011;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0001 || reg_data !== 8'hA0) begin
            errors++;
            $display("FAIL post_rst_grant gnt=%b data=%h required 0001 a0", gnt, reg_data);
        end
        wait_idle();
    endtask

    task automatic test_drop_after_sample();
        wdata = 32'h00000F00;
        req   = 4'b0010;
        tick();
        req   = 4'b0000;
        wdata = 32'h0000FF00;
        checks++;
        if (ack !== 4'b0010 || reg_ena !== 1'b1 || reg_data !== 8'h0F) begin
            errors++;
            $display("FAIL drop_write ack=%b ena=%b data=%h required 0010 1 0f", ack, reg_ena, reg_data);
        end
        tick();
        checks++;
        if (reg_data !== 8'h0F || reg_ena !== 1'b0) begin
            errors++;
            $display("FAIL drop_stable data=%h ena=%b required 0f 0", reg_data, reg_ena);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int order[4] = '{0, 1, 2, 3};
        logic [3:0] exp;
        wdata0 = 32'hB3B2B1B0;
        req0   = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c % 2 == 1) ? (4'b0001 << order[(c-1)/2]) : 4'b0000;
            checks++;
            if (gnt0 !== exp || reg_ena0 !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_gnt cycle %0d gnt=%b ena=%b required %b %b", c, gnt0, reg_ena0,
                         exp, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                checks++;
                if (reg_data0 !== 8'(8'hB0 + order[(c-1)/2])) begin
                    errors++;
                    $display("FAIL b2b_data cycle %0d data=%h required %h", c, reg_data0,
                             8'(8'hB0 + order[(c-1)/2]));
                end
            end
        end
        req0 = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_priority();
        test_reset_mid_hold();
        test_drop_after_sample();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
